// File: rtl/bridge_timer.sv
// bridge_timer -- memory-mapped countdown timer on the CPU bridge bus.
// Registers: CTRL (+0x0), PRESET (+0x4), COUNT (+0x8, read-only).
// Raises irq = CTRL.IM & irq_flag when COUNT expires.
// Optional feature macro: TIMER_PRESCALE_EN. When it is defined, COUNT steps
// once every PRESCALE clocks. When it is undefined, COUNT steps every clock.
module bridge_timer #(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t      state_q;
   logic [3:0]  ctrl_q;      // {IM, Mode[1:0], En}
   logic [31:0] preset_q;
   logic [31:0] count_q;
   logic        irq_flag_q;

   logic ctrl_en;
   logic ctrl_im;
   logic auto_reload;
   logic ctrl_wr;
   logic preset_wr;
   logic cnt_tick;
   logic expire;

   assign ctrl_en     = ctrl_q[0];
   assign ctrl_im     = ctrl_q[3];
   // Mode 1x has no meaning of its own and behaves as one-shot.
   assign auto_reload = (ctrl_q[2:1] == 2'b01);
   assign ctrl_wr     = sel && we && (addr == 2'd0);
   assign preset_wr   = sel && we && (addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
   localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

   logic [PSC_W-1:0] psc_q;

   // Prescaler: free-runs only while counting is enabled in CNT.
   // It is held at zero elsewhere, so every LOAD starts a full period.
   always_ff @(posedge clk) begin
      if (!reset) begin
         psc_q <= '0;
      end else if ((state_q != S_CNT) || !ctrl_en) begin
         psc_q <= '0;
      end else if (psc_q == PSC_LAST) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_q + 1'b1;
      end
   end

   assign cnt_tick = (psc_q == PSC_LAST);
`else
   assign cnt_tick = 1'b1;
`endif

   assign expire = (state_q == S_CNT) && ctrl_en && cnt_tick && (count_q <= 32'd1);

   // Timer FSM plus CPU register writes. The CPU write is placed after the FSM
   // update so that it takes priority over the FSM clearing En in INT.
   always_ff @(posedge clk) begin
      // NOTE: all state updates use <= so that every branch reads the
      // pre-edge values, whatever the statement order.
      if (!reset) begin
         state_q    <= S_IDLE;
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         irq_flag_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ctrl_en) state_q <= S_LOAD;
            end
            S_LOAD: begin
               count_q <= preset_q;
               state_q <= S_CNT;
            end
            S_CNT: begin
               if (ctrl_en && cnt_tick) begin
                  if (count_q > 32'd1) begin
                     count_q <= count_q - 32'd1;
                  end else begin
                     // A count of 0 or 1 expires here, so COUNT never wraps.
                     count_q <= '0;
                     state_q <= S_INT;
                  end
               end
            end
            S_INT: begin
               if (auto_reload) begin
                  state_q <= S_LOAD;
               end else begin
                  ctrl_q[0] <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (preset_wr) preset_q <= din;
         if (ctrl_wr)   ctrl_q   <= din[3:0];

         // Expiry beats a simultaneous CTRL write, so the interrupt is never lost.
         if (expire) begin
            irq_flag_q <= 1'b1;
         end else if (ctrl_wr || ((state_q == S_INT) && auto_reload)) begin
            irq_flag_q <= 1'b0;
         end
      end
   end

   // Read mux: decoded from addr alone.
   always_comb begin
      // NOTE: default assignment first, so no path leaves dout unassigned
      // (no latch).
      dout = '0;
      case (addr)
         2'd0:    dout = {28'd0, ctrl_q};
         2'd1:    dout = preset_q;
         2'd2:    dout = count_q;
         default: dout = '0;
      endcase
   end

   assign irq = ctrl_im && irq_flag_q;

endmodule

// File: tb/tb_bridge_timer.sv
// tb_bridge_timer -- directed scoreboard bench for bridge_timer.
// Stimulus pushes expected {dout, irq} for a read into a queue.
// A monitor on the falling edge pops the entry and compares it.
module tb_bridge_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   always #5 clk = ~clk;

   bridge_timer dut (
      .clk   (clk),
      .reset (reset),
      .sel   (sel),
      .addr  (addr),
      .we    (we),
      .din   (din),
      .dout  (dout),
      .irq   (irq)
   );

   typedef struct {
      string       name;
      logic [31:0] exp_dout;
      logic        exp_irq;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: sample away from the active edge and compare against the scoreboard.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check(e.name, dout, e.exp_dout);
         check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.exp_irq});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A bus write that takes effect at the next rising edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      sel  = 1'b1;
      we   = 1'b1;
      addr = a;
      din  = d;
      tick();
      sel  = 1'b0;
      we   = 1'b0;
   endtask

   // Queue the expected state after the most recent edge, then advance one edge.
   task automatic rd(input string name, input logic [1:0] a,
                     input logic [31:0] exp_d, input logic exp_i);
      exp_t e;
      addr       = a;
      e.name     = name;
      e.exp_dout = exp_d;
      e.exp_irq  = exp_i;
      sb_q.push_back(e);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // Auto-reload expectations for PRESET=2, indexed by edge after the CTRL write.
   logic [31:0] t3_cnt [16] = '{0, 0, 2, 1, 0, 0, 2, 1, 0, 0, 2, 1, 0, 0, 2, 1};
   logic        t3_irq [16] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

   initial begin
      reset = 1'b0;
      sel   = 1'b0;
      we    = 1'b0;
      addr  = 2'd0;
      din   = '0;
      tick();
      tick();
      reset = 1'b1;

      // Reset state.
      rd("rst_ctrl",   2'd0, 32'd0, 1'b0);
      rd("rst_preset", 2'd1, 32'd0, 1'b0);
      rd("rst_count",  2'd2, 32'd0, 1'b0);
      rd("rst_addr3",  2'd3, 32'd0, 1'b0);

      // Reset asserted for two edges in the middle of a count.
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      tick();
      tick();
      tick();
      rd("t1_mid_count", 2'd2, 32'd9, 1'b0);
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      rd("t1_ctrl",   2'd0, 32'd0, 1'b0);
      rd("t1_preset", 2'd1, 32'd0, 1'b0);
      rd("t1_count",  2'd2, 32'd0, 1'b0);
      rd("t1_idle",   2'd2, 32'd0, 1'b0);

      // One-shot with IM, PRESET=3.
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      rd("t2_e0", 2'd2, 32'd0, 1'b0);
      rd("t2_e1", 2'd2, 32'd0, 1'b0);
      rd("t2_e2", 2'd2, 32'd3, 1'b0);
      rd("t2_e3", 2'd2, 32'd2, 1'b0);
      rd("t2_e4", 2'd2, 32'd1, 1'b0);
      rd("t2_e5", 2'd2, 32'd0, 1'b1);
      rd("t2_en_clr", 2'd0, 32'h8, 1'b1);
      rd("t2_hold", 2'd2, 32'd0, 1'b1);
      wr(2'd0, 32'h8);
      rd("t2_ack", 2'd0, 32'h8, 1'b0);

      // Auto-reload with IM, PRESET=2: a 1-cycle irq pulse every 4 edges.
      do_reset();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      for (int i = 0; i < 16; i++) begin
         rd($sformatf("t3_e%0d", i), 2'd2, t3_cnt[i], t3_irq[i]);
      end

      // One-shot without IM, PRESET=0 (behaves as PRESET=1).
      do_reset();
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h1);
      rd("t4_e0", 2'd2, 32'd0, 1'b0);
      rd("t4_e1", 2'd2, 32'd0, 1'b0);
      rd("t4_e2", 2'd2, 32'd0, 1'b0);
      rd("t4_int", 2'd0, 32'h1, 1'b0);
      rd("t4_en_clr", 2'd0, 32'h0, 1'b0);
      wr(2'd0, 32'h8);
      rd("t4_im_on", 2'd0, 32'h8, 1'b0);

      // Pause at COUNT=5, write PRESET during the pause, then resume.
      do_reset();
      wr(2'd1, 32'd8);
      wr(2'd0, 32'h9);
      rd("t5_e0", 2'd2, 32'd0, 1'b0);
      rd("t5_e1", 2'd2, 32'd0, 1'b0);
      rd("t5_e2", 2'd2, 32'd8, 1'b0);
      rd("t5_e3", 2'd2, 32'd7, 1'b0);
      wr(2'd0, 32'h8);
      rd("t5_pause0", 2'd2, 32'd5, 1'b0);
      wr(2'd1, 32'd100);
      rd("t5_pause1", 2'd2, 32'd5, 1'b0);
      rd("t5_pause2", 2'd2, 32'd5, 1'b0);
      rd("t5_preset", 2'd1, 32'd100, 1'b0);
      rd("t5_pause3", 2'd2, 32'd5, 1'b0);
      wr(2'd0, 32'h9);
      rd("t5_resume", 2'd2, 32'd5, 1'b0);
      rd("t5_c4", 2'd2, 32'd4, 1'b0);
      rd("t5_c3", 2'd2, 32'd3, 1'b0);
      rd("t5_c2", 2'd2, 32'd2, 1'b0);
      rd("t5_c1", 2'd2, 32'd1, 1'b0);
      rd("t5_c0", 2'd2, 32'd0, 1'b1);
      rd("t5_nowrap", 2'd2, 32'd0, 1'b1);

      // COUNT is read-only, addr 3 is ignored, we without sel does nothing.
      wr(2'd2, 32'h55);
      rd("t6_count_ro", 2'd2, 32'd0, 1'b1);
      wr(2'd3, 32'h77);
      rd("t6_addr3", 2'd3, 32'd0, 1'b1);
      sel  = 1'b0;
      we   = 1'b1;
      addr = 2'd1;
      din  = 32'hDEAD;
      tick();
      addr = 2'd0;
      din  = 32'hF;
      tick();
      we   = 1'b0;
      rd("t6_nosel_preset", 2'd1, 32'd100, 1'b1);
      rd("t6_nosel_ctrl", 2'd0, 32'h8, 1'b1);
      wr(2'd0, 32'hFFFF_FFF8);
      rd("t6_ctrl_hi0", 2'd0, 32'h8, 1'b0);

      // A CTRL write on the expiry edge does not lose the interrupt.
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      rd("t7_e0", 2'd2, 32'd0, 1'b0);
      rd("t7_e1", 2'd2, 32'd0, 1'b0);
      wr(2'd0, 32'h8);
      rd("t7_expire_wr", 2'd0, 32'h8, 1'b1);
      rd("t7_after", 2'd2, 32'd0, 1'b1);

      // A CPU write in INT keeps En set, and the timer restarts.
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      rd("t8_e0", 2'd2, 32'd0, 1'b0);
      rd("t8_e1", 2'd2, 32'd0, 1'b0);
      rd("t8_e2", 2'd2, 32'd1, 1'b0);
      wr(2'd0, 32'h9);
      rd("t8_cpu_wins", 2'd0, 32'h9, 1'b0);
      rd("t8_load", 2'd2, 32'd0, 1'b0);
      rd("t8_cnt", 2'd2, 32'd1, 1'b0);
      rd("t8_expire", 2'd2, 32'd0, 1'b1);

      // Drain the scoreboard with a bounded wait.
      tick();
      tick();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
